cdnsdru_usb4_message_bus_ctrl: RTL and testbench
================================================

// Module: cdnsdru_usb4_message_bus_ctrl
// PURPOSE
//  Message-bus command controller between the MB PIPE RX decoder and the MB PIPE TX encoder.
//  Buffers write_uncommitted requests and flushes them, in order, to the PHY register port when a write_committed arrives.
//  Services reads and sends write_ack / read_completion back to the MAC through the TX encoder.
// PARAMETERS
//  UC_DEPTH    4    uncommitted-write buffer entries (2..8)
//  REG_TIMEOUT 255  cycles to wait for mb_reg_ack before abort (8-bit counter)
// PORTS
//  pipe_mac2phy_clk    in   1   MB clock; the only clock
//  pipe_mac2phy_rst    in   1   synchronous, active-high reset
//  mb_enable           in   1   MB enabled (P0, message bus active)
//  mb_cdb_reset        in   1   CDB soft reset, whole MB block
//  mb_cdb_ctrl_reset   in   1   CDB soft reset, this block only
//  mb_cdb_err_clr      in   1   clears sticky error flags
//  mb_rx_cmd_complete  in   1   one-cycle strobe: new command decoded
//  mb_rx_command       in   4   command (1 WR_UC, 2 WR_C, 3 RD, 4 RD_CPL, 5 WR_ACK)
//  mb_rx_address       in   12  command address
//  mb_rx_data          in   8   command data
//  mb_reg_req          out  1   register access request, held until ack
//  mb_reg_wr           out  1   1 = write, 0 = read (valid with req)
//  mb_reg_addr         out  12  register address
//  mb_reg_wdata        out  8   register write data
//  mb_reg_ack          in   1   one-cycle access done
//  mb_reg_rdata        in   8   read data, valid with ack
//  mb_tx_req           out  1   response request, held until done
//  mb_tx_command       out  4   4'h4 read_completion or 4'h5 write_ack
//  mb_tx_data          out  8   completion data (0 for write_ack)
//  mb_tx_done          in   1   one-cycle: TX encoder consumed response
//  mb_busy             out  1   FSM not in IDLE
//  mb_err_overflow     out  1   sticky: WR_UC dropped, buffer full
//  mb_err_timeout      out  1   sticky: register access aborted
//  mb_err_drop         out  1   sticky: command received while busy
// BEHAVIOUR
//  - Soft reset = ~mb_enable | mb_cdb_reset | mb_cdb_ctrl_reset.
//  - Soft reset has the same effect as pipe_mac2phy_rst, except the sticky error flags are held.
//  - Reset state: FSM IDLE, buffer empty, all outputs 0.
//  - Reset (either kind) mid-operation: outstanding req dropped the same cycle; no response sent.
//  - mb_cdb_err_clr clears all three flags. When set and clear coincide, set wins.
//  - States: IDLE, DRAIN, COMMIT, READ, RESP.
//  - IDLE, on strobe:
//    - WR_UC: if count < UC_DEPTH, push {addr,data}; else set mb_err_overflow.
//      Stay in IDLE, no response.
//    - WR_C: latch addr/data; go to DRAIN if count > 0, else COMMIT.
//    - RD: latch addr; go to READ.
//    - RD_CPL, WR_ACK, other: ignored.
//  - DRAIN: write the head entry (req=1, wr=1); on ack pop it.
//    - When the buffer becomes empty, go to COMMIT.
//    - Order is FIFO; write pointers wrap modulo UC_DEPTH.
//  - COMMIT: write the latched committed addr/data; on ack load tx_command=5, tx_data=0; go to RESP.
//  - READ: req=1, wr=0; on ack load tx_command=4, tx_data=mb_reg_rdata; go to RESP.
//  - RESP: tx_req=1 with stable command/data; on mb_tx_done, deassert the next cycle and go to IDLE.
//  - Latency: mb_reg_req rises 1 cycle after the strobe; mb_tx_req rises 1 cycle after the final ack.
//  - Timeout: counter resets at each req start and increments while req=1 and no ack.
//    At REG_TIMEOUT, req drops and mb_err_timeout is set.
//    - Aborted drain entry: popped, drain continues.
//    - Aborted COMMIT: write_ack still sent.
//    - Aborted READ: read_completion with data 8'h00.
//  - Strobe while not IDLE: command discarded, mb_err_drop set, FSM unaffected.
//  - Strobe in the same cycle as the RESP to IDLE transition: also dropped.
//  - mb_busy = (state != IDLE).
// TESTING
//  - 3x WR_UC (0x010/A1, 0x011/A2, 0x012/A3), then WR_C 0x020/B0:
//    4 writes in order A1,A2,A3,B0, then one write_ack, tx_data=0.
//  - RD 0x105, ack with rdata=0x5C after 3 cycles:
//    tx_command=4, tx_data=0x5C, mb_tx_req held until mb_tx_done.
//  - 5x WR_UC with UC_DEPTH=4: 5th dropped, mb_err_overflow=1.
//    Following WR_C flushes exactly 4 entries.
//  - RD with ack never returned: req drops after 255 cycles, mb_err_timeout=1, read_completion data 0x00.
//  - WR_C strobe while in READ: mb_err_drop=1; the read completes normally; no write issued.
//  - mb_enable low during DRAIN: next cycle req=0, IDLE, buffer empty, no write_ack.
//    After re-enable, a WR_C performs a single write.

Source files
------------

// File: rtl/cdnsdru_usb4_message_bus_ctrl.sv
// Message-bus command controller: buffers uncommitted writes, flushes them on commit,
// services reads and returns write_ack / read_completion through the TX encoder.
module cdnsdru_usb4_message_bus_ctrl #(
    parameter int unsigned UC_DEPTH    = 4,
    parameter int unsigned REG_TIMEOUT = 255
) (
    input  logic        pipe_mac2phy_clk,
    input  logic        pipe_mac2phy_rst,
    input  logic        mb_enable,
    input  logic        mb_cdb_reset,
    input  logic        mb_cdb_ctrl_reset,
    input  logic        mb_cdb_err_clr,
    input  logic        mb_rx_cmd_complete,
    input  logic [3:0]  mb_rx_command,
    input  logic [11:0] mb_rx_address,
    input  logic [7:0]  mb_rx_data,
    output logic        mb_reg_req,
    output logic        mb_reg_wr,
    output logic [11:0] mb_reg_addr,
    output logic [7:0]  mb_reg_wdata,
    input  logic        mb_reg_ack,
    input  logic [7:0]  mb_reg_rdata,
    output logic        mb_tx_req,
    output logic [3:0]  mb_tx_command,
    output logic [7:0]  mb_tx_data,
    input  logic        mb_tx_done,
    output logic        mb_busy,
    output logic        mb_err_overflow,
    output logic        mb_err_timeout,
    output logic        mb_err_drop
);

    localparam int unsigned PtrW    = (UC_DEPTH > 1) ? $clog2(UC_DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(UC_DEPTH + 1);
    localparam logic [7:0]  TmoLast = 8'(REG_TIMEOUT - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(UC_DEPTH - 1);

    localparam logic [3:0] CmdWrUc  = 4'h1;
    localparam logic [3:0] CmdWrC   = 4'h2;
    localparam logic [3:0] CmdRd    = 4'h3;
    localparam logic [3:0] CmdRdCpl = 4'h4;
    localparam logic [3:0] CmdWrAck = 4'h5;

    typedef enum logic [2:0] {StIdle, StDrain, StCommit, StRead, StResp} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [11:0]       c_addr_q, c_addr_d;
    logic [7:0]        c_data_q, c_data_d;
    logic [3:0]        tx_cmd_q, tx_cmd_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        tmr_q, tmr_d;
    logic              err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d, err_drop_q, err_drop_d;
    logic              set_ovf, set_tmo, set_drop, push;
    logic [11:0]       buf_addr_q [UC_DEPTH];
    logic [7:0]        buf_data_q [UC_DEPTH];

    logic soft_rst, any_rst, in_access, tmo_hit, access_done;
    logic [7:0] rd_data_eff;

    assign soft_rst  = ~mb_enable | mb_cdb_reset | mb_cdb_ctrl_reset;
    assign any_rst   = pipe_mac2phy_rst | soft_rst;
    assign in_access = (state_q == StDrain) || (state_q == StCommit) || (state_q == StRead);

    // Request is gated by reset combinationally so an outstanding access drops immediately.
    assign mb_reg_req  = in_access & ~any_rst;
    assign mb_reg_wr   = mb_reg_req & (state_q != StRead);
    assign tmo_hit     = mb_reg_req & ~mb_reg_ack & (tmr_q == TmoLast);
    assign access_done = mb_reg_req & (mb_reg_ack | tmo_hit);
    assign rd_data_eff = mb_reg_ack ? mb_reg_rdata : 8'h00;

    assign mb_tx_req       = (state_q == StResp) & ~any_rst;
    assign mb_tx_command   = tx_cmd_q;
    assign mb_tx_data      = tx_data_q;
    assign mb_busy         = (state_q != StIdle);
    assign mb_err_overflow = err_ovf_q;
    assign mb_err_timeout  = err_tmo_q;
    assign mb_err_drop     = err_drop_q;

    always_comb begin
        mb_reg_addr  = 12'h000;
        mb_reg_wdata = 8'h00;
        unique case (state_q)
            StDrain: begin
                mb_reg_addr  = buf_addr_q[rd_ptr_q];
                mb_reg_wdata = buf_data_q[rd_ptr_q];
            end
            StCommit: begin
                mb_reg_addr  = c_addr_q;
                mb_reg_wdata = c_data_q;
            end
            StRead:  mb_reg_addr = c_addr_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        c_addr_d  = c_addr_q;
        c_data_d  = c_data_q;
        tx_cmd_d  = tx_cmd_q;
        tx_data_d = tx_data_q;
        tmr_d     = (mb_reg_req && !access_done) ? tmr_q + 8'd1 : 8'd0;
        push      = 1'b0;
        set_ovf   = 1'b0;
        set_tmo   = tmo_hit;
        set_drop  = mb_rx_cmd_complete && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (mb_rx_cmd_complete) begin
                    case (mb_rx_command)
                        CmdWrUc: begin
                            if (cnt_q < CntW'(UC_DEPTH)) push = 1'b1;
                            else                         set_ovf = 1'b1;
                        end
                        CmdWrC: begin
                            c_addr_d = mb_rx_address;
                            c_data_d = mb_rx_data;
                            state_d  = (cnt_q != '0) ? StDrain : StCommit;
                        end
                        CmdRd: begin
                            c_addr_d = mb_rx_address;
                            state_d  = StRead;
                        end
                        default: ;
                    endcase
                end
            end
            StDrain: begin
                // An aborted entry is popped just like an acknowledged one.
                if (access_done) begin
                    rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) state_d = StCommit;
                end
            end
            StCommit: begin
                if (access_done) begin
                    tx_cmd_d  = CmdWrAck;
                    tx_data_d = 8'h00;
                    state_d   = StResp;
                end
            end
            StRead: begin
                if (access_done) begin
                    tx_cmd_d  = CmdRdCpl;
                    tx_data_d = rd_data_eff;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (mb_tx_done) begin
                    tx_cmd_d  = 4'h0;
                    tx_data_d = 8'h00;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
        end

        // Soft reset clears everything except the sticky error flags.
        if (any_rst) begin
            state_d   = StIdle;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            cnt_d     = '0;
            c_addr_d  = 12'h000;
            c_data_d  = 8'h00;
            tx_cmd_d  = 4'h0;
            tx_data_d = 8'h00;
            tmr_d     = 8'd0;
            push      = 1'b0;
            set_ovf   = 1'b0;
            set_tmo   = 1'b0;
            set_drop  = 1'b0;
        end

        err_ovf_d  = set_ovf  | (err_ovf_q  & ~mb_cdb_err_clr);
        err_tmo_d  = set_tmo  | (err_tmo_q  & ~mb_cdb_err_clr);
        err_drop_d = set_drop | (err_drop_q & ~mb_cdb_err_clr);
    end

    always_ff @(posedge pipe_mac2phy_clk) begin
        if (pipe_mac2phy_rst) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            c_addr_q   <= 12'h000;
            c_data_q   <= 8'h00;
            tx_cmd_q   <= 4'h0;
            tx_data_q  <= 8'h00;
            tmr_q      <= 8'd0;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            c_addr_q   <= c_addr_d;
            c_data_q   <= c_data_d;
            tx_cmd_q   <= tx_cmd_d;
            tx_data_q  <= tx_data_d;
            tmr_q      <= tmr_d;
            err_ovf_q  <= err_ovf_d;
            err_tmo_q  <= err_tmo_d;
            err_drop_q <= err_drop_d;
        end
    end

    always_ff @(posedge pipe_mac2phy_clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= mb_rx_address;
            buf_data_q[wr_ptr_q] <= mb_rx_data;
        end
    end

endmodule

// File: tb/tb_cdnsdru_usb4_message_bus_ctrl.sv
// Randomised directed bench for the message-bus controller against a queue-based model.
module tb_cdnsdru_usb4_message_bus_ctrl;

    localparam int unsigned UC_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, mb_enable, mb_cdb_reset, mb_cdb_ctrl_reset, mb_cdb_err_clr;
    logic        mb_rx_cmd_complete;
    logic [3:0]  mb_rx_command;
    logic [11:0] mb_rx_address;
    logic [7:0]  mb_rx_data;
    logic        mb_reg_req, mb_reg_wr, mb_reg_ack;
    logic [11:0] mb_reg_addr;
    logic [7:0]  mb_reg_wdata, mb_reg_rdata;
    logic        mb_tx_req, mb_tx_done;
    logic [3:0]  mb_tx_command;
    logic [7:0]  mb_tx_data;
    logic        mb_busy, mb_err_overflow, mb_err_timeout, mb_err_drop;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending uncommitted writes as {addr, data}, plus sticky flags.
    logic [19:0] uc_q[$];
    logic        m_ovf = 1'b0, m_tmo = 1'b0, m_drop = 1'b0;

    cdnsdru_usb4_message_bus_ctrl #(.UC_DEPTH(UC_DEPTH), .REG_TIMEOUT(255)) dut (
        .pipe_mac2phy_clk   (clk),
        .pipe_mac2phy_rst   (rst),
        .mb_enable          (mb_enable),
        .mb_cdb_reset       (mb_cdb_reset),
        .mb_cdb_ctrl_reset  (mb_cdb_ctrl_reset),
        .mb_cdb_err_clr     (mb_cdb_err_clr),
        .mb_rx_cmd_complete (mb_rx_cmd_complete),
        .mb_rx_command      (mb_rx_command),
        .mb_rx_address      (mb_rx_address),
        .mb_rx_data         (mb_rx_data),
        .mb_reg_req         (mb_reg_req),
        .mb_reg_wr          (mb_reg_wr),
        .mb_reg_addr        (mb_reg_addr),
        .mb_reg_wdata       (mb_reg_wdata),
        .mb_reg_ack         (mb_reg_ack),
        .mb_reg_rdata       (mb_reg_rdata),
        .mb_tx_req          (mb_tx_req),
        .mb_tx_command      (mb_tx_command),
        .mb_tx_data         (mb_tx_data),
        .mb_tx_done         (mb_tx_done),
        .mb_busy            (mb_busy),
        .mb_err_overflow    (mb_err_overflow),
        .mb_err_timeout     (mb_err_timeout),
        .mb_err_drop        (mb_err_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ovf"},  mb_err_overflow, m_ovf);
        chk({tag, "_tmo"},  mb_err_timeout,  m_tmo);
        chk({tag, "_drop"}, mb_err_drop,     m_drop);
    endtask

    task automatic strobe(input logic [3:0] cmd, input logic [11:0] a, input logic [7:0] d);
        mb_rx_cmd_complete = 1'b1;
        mb_rx_command      = cmd;
        mb_rx_address      = a;
        mb_rx_data         = d;
        step();
        mb_rx_cmd_complete = 1'b0;
        mb_rx_command      = 4'h0;
    endtask

    task automatic send_wr_uc(input logic [11:0] a, input logic [7:0] d);
        strobe(4'h1, a, d);
        if (uc_q.size() < UC_DEPTH) uc_q.push_back({a, d});
        else                        m_ovf = 1'b1;
        chk("wruc_idle_busy", mb_busy, 1'b0);
    endtask

    task automatic do_access(input logic exp_wr, input logic [11:0] a, input logic [7:0] d,
                             input int delay, input logic [7:0] rdata);
        int n = 0;
        while (!mb_reg_req && n < 50) begin
            step();
            n++;
        end
        chk("acc_req", mb_reg_req, 1'b1);
        chk("acc_wr", mb_reg_wr, exp_wr);
        chk("acc_addr", mb_reg_addr, a);
        if (exp_wr) chk("acc_wdata", mb_reg_wdata, d);
        repeat (delay) begin
            step();
            chk("acc_req_held", mb_reg_req, 1'b1);
        end
        mb_reg_ack   = 1'b1;
        mb_reg_rdata = rdata;
        step();
        mb_reg_ack   = 1'b0;
        mb_reg_rdata = 8'($urandom);
    endtask

    task automatic do_resp(input logic [3:0] cmd, input logic [7:0] d, input int hold);
        int n = 0;
        while (!mb_tx_req && n < 50) begin
            step();
            n++;
        end
        chk("tx_req", mb_tx_req, 1'b1);
        chk("tx_cmd", mb_tx_command, cmd);
        chk("tx_data", mb_tx_data, d);
        repeat (hold) begin
            step();
            chk("tx_req_held", mb_tx_req, 1'b1);
            chk("tx_data_held", mb_tx_data, d);
        end
        mb_tx_done = 1'b1;
        step();
        mb_tx_done = 1'b0;
        chk("tx_req_drop", mb_tx_req, 1'b0);
        chk("tx_idle", mb_busy, 1'b0);
    endtask

    task automatic wr_c_flow(input logic [11:0] a, input logic [7:0] d, input int hold);
        logic [19:0] exp_q[$];
        exp_q = uc_q;
        exp_q.push_back({a, d});
        uc_q.delete();
        strobe(4'h2, a, d);
        chk("wrc_req_latency", mb_reg_req, 1'b1);
        foreach (exp_q[i]) begin
            logic [19:0] e;
            e = exp_q[i];
            do_access(1'b1, e[19:8], e[7:0], int'($urandom_range(0, 3)), 8'($urandom));
        end
        chk("wrc_tx_latency", mb_tx_req, 1'b1);
        do_resp(4'h5, 8'h00, hold);
    endtask

    task automatic rd_flow(input logic [11:0] a, input logic [7:0] rdata, input int delay);
        strobe(4'h3, a, 8'($urandom));
        chk("rd_req_latency", mb_reg_req, 1'b1);
        do_access(1'b0, a, 8'h00, delay, rdata);
        chk("rd_tx_latency", mb_tx_req, 1'b1);
        do_resp(4'h4, rdata, int'($urandom_range(0, 3)));
    endtask

    task automatic pulse_err_clr();
        mb_cdb_err_clr = 1'b1;
        step();
        mb_cdb_err_clr = 1'b0;
        m_ovf = 1'b0;
        m_tmo = 1'b0;
        m_drop = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        mb_enable = 1'b1;
        mb_cdb_reset = 1'b0;
        mb_cdb_ctrl_reset = 1'b0;
        mb_cdb_err_clr = 1'b0;
        mb_rx_cmd_complete = 1'b0;
        mb_rx_command = 4'h0;
        mb_rx_address = 12'h000;
        mb_rx_data = 8'h00;
        mb_reg_ack = 1'b0;
        mb_reg_rdata = 8'h00;
        mb_tx_done = 1'b0;
        repeat (3) step();
        chk("rst_busy", mb_busy, 1'b0);
        chk("rst_req", mb_reg_req, 1'b0);
        chk("rst_tx_req", mb_tx_req, 1'b0);
        chk("rst_tx_cmd", mb_tx_command, 4'h0);
        chk("rst_addr", mb_reg_addr, 12'h000);
        chk_flags("rst");
        rst = 1'b0;
        step();

        // Three buffered writes then a commit flush in order.
        send_wr_uc(12'h010, 8'hA1);
        send_wr_uc(12'h011, 8'hA2);
        send_wr_uc(12'h012, 8'hA3);
        wr_c_flow(12'h020, 8'hB0, 2);

        rd_flow(12'h105, 8'h5C, 3);

        // Overflow: fifth write dropped, commit flushes four plus the committed one.
        for (int i = 0; i < 5; i++) send_wr_uc(12'h200 + 12'(i), 8'h30 + 8'(i));
        chk_flags("ovf");
        wr_c_flow(12'h2FF, 8'hEE, 1);
        pulse_err_clr();
        chk_flags("clr");

        // Read whose ack never comes.
        strobe(4'h3, 12'h0AB, 8'h00);
        n = 0;
        while (mb_reg_req && n < 400) begin
            n++;
            step();
        end
        m_tmo = 1'b1;
        chk("tmo_req_cycles", n, 255);
        chk("tmo_tx_req", mb_tx_req, 1'b1);
        chk_flags("tmo");
        do_resp(4'h4, 8'h00, 1);

        // Commit arriving during a read is dropped; clear in the same cycle loses to set.
        strobe(4'h3, 12'h0C3, 8'h00);
        mb_cdb_err_clr = 1'b1;
        strobe(4'h2, 12'h300, 8'h77);
        mb_cdb_err_clr = 1'b0;
        m_ovf = 1'b0;
        m_tmo = 1'b0;
        m_drop = 1'b1;
        chk_flags("drop");
        do_access(1'b0, 12'h0C3, 8'h00, 1, 8'h9E);
        do_resp(4'h4, 8'h9E, 0);
        repeat (3) begin
            step();
            chk("drop_no_write", mb_reg_req, 1'b0);
        end

        // Disable mid-drain: request drops at once, buffer is discarded, flags held.
        send_wr_uc(12'h040, 8'h11);
        send_wr_uc(12'h041, 8'h22);
        strobe(4'h2, 12'h050, 8'h33);
        do_access(1'b1, 12'h040, 8'h11, 0, 8'h00);
        chk("dis_second_entry", mb_reg_addr, 12'h041);
        mb_enable = 1'b0;
        #1;
        chk("dis_req_same_cycle", mb_reg_req, 1'b0);
        step();
        uc_q.delete();
        chk("dis_busy", mb_busy, 1'b0);
        chk("dis_req", mb_reg_req, 1'b0);
        chk("dis_tx_req", mb_tx_req, 1'b0);
        chk_flags("dis");
        mb_enable = 1'b1;
        step();
        chk("dis_tx_req_after", mb_tx_req, 1'b0);
        wr_c_flow(12'h060, 8'h44, 0);

        // Strobe coinciding with the RESP-to-IDLE transition is dropped.
        strobe(4'h3, 12'h07F, 8'h00);
        do_access(1'b0, 12'h07F, 8'h00, 0, 8'h12);
        chk("coin_tx_req", mb_tx_req, 1'b1);
        mb_tx_done = 1'b1;
        mb_rx_cmd_complete = 1'b1;
        mb_rx_command = 4'h1;
        mb_rx_address = 12'h0EE;
        mb_rx_data = 8'h55;
        step();
        mb_tx_done = 1'b0;
        mb_rx_cmd_complete = 1'b0;
        m_drop = 1'b1;
        chk("coin_idle", mb_busy, 1'b0);
        chk_flags("coin");
        wr_c_flow(12'h070, 8'h66, 0);

        for (int it = 0; it < 30; it++) begin
            int k;
            k = int'($urandom_range(0, 5));
            for (int j = 0; j < k; j++) send_wr_uc(12'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 0)
                wr_c_flow(12'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
            else
                rd_flow(12'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
            chk_flags("rand");
            if ($urandom_range(0, 3) == 0) pulse_err_clr();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
